// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter.
// Digit width, FSM state encoding and the BCD digit validity check.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Reverse double-dabble digit correction: a shifted digit of 8 or more
// gets 3 subtracted (4-bit only, no borrow into the neighbour digit).
module bcd_adj3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= 4'd8) ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Iterative NDIG-digit BCD to NBIN-bit binary converter (go/done handshake).
// One right shift plus per-digit correction per clock; NBIN shifts total.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int NBIN = 10
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        go,
  input  logic [BCD_DIGIT_W*NDIG-1:0] p,
  output logic [NBIN-1:0]             b,
  output logic                        done,
  output logic                        busy,
  output logic                        err,
  output logic                        ovf
);

  localparam int BW  = BCD_DIGIT_W * NDIG;
  localparam int SRW = BW + NBIN;
  localparam int CW  = $clog2(NBIN + 1);

  state_t           state_q, state_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBIN-1:0]  b_q, b_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic [SRW-1:0]   sr_sh;
  logic [SRW-1:0]   sr_adj;
  logic             p_ok;

  // sr = {bcd field, bin field}; bits fall from the BCD side into bin
  assign sr_sh = sr_q >> 1;
  assign sr_adj[NBIN-1:0] = sr_sh[NBIN-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d_i (sr_sh[NBIN + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (sr_adj[NBIN + g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    p_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!is_bcd_digit(p[i*BCD_DIGIT_W +: BCD_DIGIT_W])) p_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    done_d  = done_q;
    busy_d  = busy_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (go) begin
          ovf_d = 1'b0;
          if (!p_ok) begin
            b_d     = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            sr_d    = {p, {NBIN{1'b0}}};
            cnt_d   = CW'(NBIN);
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        sr_d  = sr_adj;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          b_d     = sr_adj[NBIN-1:0];
          // leftover BCD weight means the value did not fit in NBIN bits
          ovf_d   = |sr_adj[SRW-1:NBIN];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!go) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign b    = b_q;
  assign done = done_q;
  assign busy = busy_q;
  assign err  = err_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: NBIN=10 main instance and an NBIN=8
// instance for the overflow case; expected values are hand-computed.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        go = 1'b0, go8 = 1'b0;
  logic [11:0] p = '0, p8 = '0;
  logic [9:0]  b;
  logic [7:0]  b8;
  logic        done, busy, err, ovf;
  logic        done8, busy8, err8, ovf8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd2bin_seq #(.NDIG(3), .NBIN(10)) dut (
    .clk(clk), .clr(clr), .go(go), .p(p),
    .b(b), .done(done), .busy(busy), .err(err), .ovf(ovf)
  );

  bcd2bin_seq #(.NDIG(3), .NBIN(8)) dut8 (
    .clk(clk), .clr(clr), .go(go8), .p(p8),
    .b(b8), .done(done8), .busy(busy8), .err(err8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load value, count edges (load edge included) until done, then check
  // result; unless hold is set, release go and confirm return to IDLE.
  task automatic convert(input string tag, input bit sel8, input logic [11:0] val,
                         input int exp_b, input bit exp_err, input bit exp_ovf,
                         input int exp_lat, input bit hold);
    int lat = 0, bc = 0, ovl = 0;
    logic d, bz, e, o;
    logic [31:0] bv;
    if (sel8) begin p8 = val; go8 = 1'b1; end
    else      begin p  = val; go  = 1'b1; end
    do begin
      step();
      lat++;
      if (lat == 1 && !hold) begin go = 1'b0; go8 = 1'b0; end
      d  = sel8 ? done8 : done;
      bz = sel8 ? busy8 : busy;
      if (bz) bc++;
      if (d && bz) ovl++;
    end while (!d && lat < 40);
    e  = sel8 ? err8 : err;
    o  = sel8 ? ovf8 : ovf;
    bv = sel8 ? {24'd0, b8} : {22'd0, b};
    chk({tag, " done"}, {31'd0, d}, 32'd1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_cycles"}, bc, exp_lat - 1);
    chk({tag, " done_busy_overlap"}, ovl, 0);
    chk({tag, " b"}, bv, exp_b);
    chk({tag, " err"}, {31'd0, e}, {31'd0, exp_err});
    chk({tag, " ovf"}, {31'd0, o}, {31'd0, exp_ovf});
    if (!hold) begin
      step();
      chk({tag, " idle_done"}, {31'd0, sel8 ? done8 : done}, 32'd0);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst done", {31'd0, done}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst b", {22'd0, b}, 0);
    chk("rst err", {31'd0, err}, 0);
    chk("rst ovf", {31'd0, ovf}, 0);
    chk("rst b8", {24'd0, b8}, 0);
    clr = 1'b0;
    step();

    convert("h255", 1'b0, 12'h255, 255, 1'b0, 1'b0, 11, 1'b0);
    convert("h1A3", 1'b0, 12'h1A3, 0,   1'b1, 1'b0, 1,  1'b0);
    convert("h999", 1'b0, 12'h999, 999, 1'b0, 1'b0, 11, 1'b0);
    convert("h000", 1'b0, 12'h000, 0,   1'b0, 1'b0, 11, 1'b0);
    convert("h001", 1'b0, 12'h001, 1,   1'b0, 1'b0, 11, 1'b0);
    convert("hA00", 1'b0, 12'hA00, 0,   1'b1, 1'b0, 1,  1'b0);
    convert("n8_h300", 1'b1, 12'h300, 44, 1'b0, 1'b1, 9, 1'b0);
    convert("n8_h255", 1'b1, 12'h255, 255, 1'b0, 1'b0, 9, 1'b0);

    // go held through completion: no restart
    convert("hold_h077", 1'b0, 12'h077, 77, 1'b0, 1'b0, 11, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold done", {31'd0, done}, 1);
      chk("hold busy", {31'd0, busy}, 0);
    end
    chk("hold b", {22'd0, b}, 77);
    go = 1'b0;
    step();
    chk("hold release done", {31'd0, done}, 0);
    convert("h042", 1'b0, 12'h042, 42, 1'b0, 1'b0, 11, 1'b0);

    // p change and go pulse during CALC must not disturb the result
    p = 12'h321; go = 1'b1;
    step();
    go = 1'b0; p = 12'h999;
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    begin
      int lat = 3;
      while (!done && lat < 40) begin step(); lat++; end
      chk("midcalc latency", lat, 11);
    end
    chk("midcalc b", {22'd0, b}, 321);
    chk("midcalc err", {31'd0, err}, 0);
    step();
    chk("midcalc idle done", {31'd0, done}, 0);
    step();
    chk("midcalc no restart busy", {31'd0, busy}, 0);

    // clr on the 4th CALC edge aborts everything
    p = 12'h555; go = 1'b1;
    step();
    go = 1'b0;
    step(); step(); step();
    chk("preclr busy", {31'd0, busy}, 1);
    clr = 1'b1;
    step();
    chk("clr busy", {31'd0, busy}, 0);
    chk("clr done", {31'd0, done}, 0);
    chk("clr b", {22'd0, b}, 0);
    chk("clr err", {31'd0, err}, 0);
    chk("clr ovf", {31'd0, ovf}, 0);
    clr = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("postclr idle done", {31'd0, done}, 0);
    chk("postclr idle busy", {31'd0, busy}, 0);
    convert("postclr_h555", 1'b0, 12'h555, 555, 1'b0, 1'b0, 11, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
